// File: rtl/fft_stage_sequencer_if.sv
// Issue/writeback bundle between the FFT stage sequencer and its surroundings.
// The slave modport is the sequencer side; the master modport drives start/stall/wb_valid.
interface fft_stage_sequencer_if #(
  parameter int N            = 32,
  parameter int MAX_INFLIGHT = 8
);
  localparam int STAGE_W = $clog2($clog2(N));
  localparam int PAIR_W  = $clog2(N / 2);
  localparam int CNT_W   = $clog2(MAX_INFLIGHT + 1);

  logic               start;
  logic               stall;
  logic               wb_valid;
  logic               agu_valid;
  logic [STAGE_W-1:0] stage;
  logic [PAIR_W-1:0]  pair_id;
  logic [CNT_W-1:0]   inflight;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, stall, wb_valid,
    input  agu_valid, stage, pair_id, inflight, busy, done, err
  );

  modport slave (
    input  start, stall, wb_valid,
    output agu_valid, stage, pair_id, inflight, busy, done, err
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Stage/pair walker for an in-place radix-2 FFT: issues butterflies to the AGU,
// throttles on stall and in-flight limit, and drains writebacks between stages.
module fft_stage_sequencer #(
  parameter int N            = 32,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_stage_sequencer_if.slave bus
);
  localparam int LOG2N   = $clog2(N);
  localparam int STAGE_W = $clog2(LOG2N);
  localparam int PAIR_W  = $clog2(N / 2);
  localparam int CNT_W   = $clog2(MAX_INFLIGHT + 1);

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2N - 1);
  localparam logic [PAIR_W-1:0]  LAST_PAIR  = PAIR_W'(N / 2 - 1);
  localparam logic [CNT_W-1:0]   MAX_CNT    = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e             state_q;
  logic [STAGE_W-1:0] stage_q;
  logic [PAIR_W-1:0]  pair_q;
  logic [CNT_W-1:0]   inflight_q;
  logic [CNT_W-1:0]   inflight_d;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               issue_ok;
  logic               wb_orphan;

  // A same-cycle writeback frees a slot, so a full window can still issue.
  always_comb begin
    issue_ok   = (state_q == RUN) && !bus.stall &&
                 ((inflight_q < MAX_CNT) || bus.wb_valid);
    wb_orphan  = bus.wb_valid && (inflight_q == '0) && !issue_ok;
    inflight_d = inflight_q;
    if (issue_ok && !bus.wb_valid) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!issue_ok && bus.wb_valid && (inflight_q != '0)) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      pair_q     <= '0;
      inflight_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            stage_q <= '0;
            pair_q  <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        RUN: begin
          if (issue_ok) begin
            if (pair_q == LAST_PAIR) begin
              pair_q  <= '0;
              state_q <= DRAIN;
            end else begin
              pair_q <= pair_q + PAIR_W'(1);
            end
          end
        end
        DRAIN: begin
          // Next stage reads what this stage wrote, so wait for every writeback.
          if (inflight_q == '0) begin
            if (stage_q == LAST_STAGE) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              stage_q <= stage_q + STAGE_W'(1);
              state_q <= RUN;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (wb_orphan) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.agu_valid = issue_ok;
  assign bus.stage     = stage_q;
  assign bus.pair_id   = pair_q;
  assign bus.inflight  = inflight_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer (N=32, MAX_INFLIGHT=8): cycle table plus
// hand-written sequences for stall, in-flight limit, drain delay and mid-run reset.
module tb_fft_stage_sequencer;
  localparam int N         = 32;
  localparam int MAXI      = 8;
  localparam int NPAIR     = N / 2;
  localparam int TOTAL     = 5 * NPAIR;

  logic clk;
  logic reset;

  fft_stage_sequencer_if #(.N(N), .MAX_INFLIGHT(MAXI)) bus ();

  fft_stage_sequencer #(.N(N), .MAX_INFLIGHT(MAXI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [3:0] hist;
  logic       auto_wb;
  logic       manual_wb;
  int         pend;
  int         hold_idx;
  int         wb_seen;
  int         exp_stage;
  int         exp_pair;
  int         issues;
  int         done_cnt;

  typedef struct {
    logic st;
    logic sl;
    logic wb;
    int   av;
    int   stg;
    int   pr;
    int   inf;
    int   bsy;
    int   dn;
    int   er;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, observe 1ns later, log any issue.
  task automatic cyc(input logic st, input logic sl);
    logic w;
    @(negedge clk);
    bus.start = st;
    bus.stall = sl;
    w = auto_wb ? hist[3] : manual_wb;
    if (pend > 0) begin
      pend--;
      if (pend == 0) w = 1'b1;
    end else if (w && (wb_seen == hold_idx)) begin
      pend = 10;
      w    = 1'b0;
    end
    if (w) wb_seen++;
    bus.wb_valid = w;
    #1;
    hist = {hist[2:0], bus.agu_valid};
    if (bus.done) done_cnt++;
    if (bus.agu_valid) begin
      chk("issue_stage", 32'(bus.stage), exp_stage);
      chk("issue_pair", 32'(bus.pair_id), exp_pair);
      issues++;
      if (exp_pair == NPAIR - 1) begin
        exp_pair = 0;
        exp_stage++;
      end else begin
        exp_pair++;
      end
    end
  endtask

  task automatic clear_model();
    exp_stage = 0;
    exp_pair  = 0;
    issues    = 0;
    done_cnt  = 0;
    wb_seen   = 0;
    pend      = 0;
    hist      = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.stall    = 1'b0;
    bus.wb_valid = 1'b0;
    clear_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic begin_xfer();
    clear_model();
    cyc(1'b1, 1'b0);
  endtask

  task automatic run_to_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    if (done_cnt == 0) chk({tag, "_done_timeout"}, 0, 1);
    chk({tag, "_done_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done_stage"}, 32'(bus.stage), 4);
    chk({tag, "_done_pair"}, 32'(bus.pair_id), 0);
    repeat (3) cyc(1'b0, 1'b0);
    chk({tag, "_issues"}, issues, TOTAL);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_inflight_end"}, 32'(bus.inflight), 0);
  endtask

  initial begin
    int n;
    int t_zero;
    int t_iss;
    logic found;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.stall    = 1'b0;
    bus.wb_valid = 1'b0;
    auto_wb      = 1'b0;
    manual_wb    = 1'b0;
    hold_idx     = -1;
    clear_model();

    //           st    sl    wb    av stg pr inf bsy dn er
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1, 0, 1, 1, 1, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 0, 0, 2, 2, 1, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 0, 0, 2, 2, 1, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1, 0, 2, 2, 1, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1, 0, 3, 2, 1, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1, 0, 4, 3, 1, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1, 0, 5, 3, 1, 0, 0};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state, orphan writeback in IDLE, start clearing err, stall, start in RUN.
    for (int i = 0; i < 12; i++) begin
      manual_wb = tbl[i].wb;
      cyc(tbl[i].st, tbl[i].sl);
      chk($sformatf("v%0d_agu_valid", i), 32'(bus.agu_valid), tbl[i].av);
      chk($sformatf("v%0d_stage", i), 32'(bus.stage), tbl[i].stg);
      chk($sformatf("v%0d_pair_id", i), 32'(bus.pair_id), tbl[i].pr);
      chk($sformatf("v%0d_inflight", i), 32'(bus.inflight), tbl[i].inf);
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), tbl[i].bsy);
      chk($sformatf("v%0d_done", i), 32'(bus.done), tbl[i].dn);
      chk($sformatf("v%0d_err", i), 32'(bus.err), tbl[i].er);
    end
    manual_wb = 1'b0;
    do_reset();

    // Full transform with writebacks four cycles after issue.
    auto_wb = 1'b1;
    begin_xfer();
    run_to_done("full");

    // Three-cycle stall at stage 2, pair 5.
    begin_xfer();
    n = 0;
    while (!(bus.agu_valid && bus.stage == 2 && bus.pair_id == 4) && n < 500) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    chk("stall_reach_s2p4", n < 500 ? 1 : 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1);
      chk($sformatf("stall%0d_agu_valid", k), 32'(bus.agu_valid), 0);
      chk($sformatf("stall%0d_stage", k), 32'(bus.stage), 2);
      chk($sformatf("stall%0d_pair", k), 32'(bus.pair_id), 5);
    end
    cyc(1'b0, 1'b0);
    chk("stall_resume_valid", 32'(bus.agu_valid), 1);
    chk("stall_resume_pair", 32'(bus.pair_id), 5);
    run_to_done("stall");

    // Last writeback of stage 0 held back ten cycles.
    hold_idx = NPAIR - 1;
    begin_xfer();
    n = 0;
    while (issues < NPAIR && n < 500) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    t_zero = -1;
    t_iss  = -1;
    for (int c = 0; c < 100 && t_iss < 0; c++) begin
      cyc(1'b0, 1'b0);
      if (bus.inflight == 0 && t_zero < 0) t_zero = c;
      if (bus.agu_valid) begin
        t_iss = c;
        chk("drain_first_stage", 32'(bus.stage), 1);
      end
    end
    chk("drain_inflight_zero_at", t_zero, 14);
    chk("drain_issue_after_zero", t_iss, t_zero + 1);
    hold_idx = -1;
    run_to_done("drain");

    // Writebacks withheld: in-flight window fills, one writeback frees one issue.
    auto_wb   = 1'b0;
    manual_wb = 1'b0;
    begin_xfer();
    repeat (20) cyc(1'b0, 1'b0);
    chk("window_issues", issues, 8);
    chk("window_inflight", 32'(bus.inflight), 8);
    chk("window_agu_valid", 32'(bus.agu_valid), 0);
    manual_wb = 1'b1;
    cyc(1'b0, 1'b0);
    chk("window_wb_issue", 32'(bus.agu_valid), 1);
    manual_wb = 1'b0;
    repeat (5) cyc(1'b0, 1'b0);
    chk("window_issues_after", issues, 9);
    chk("window_inflight_after", 32'(bus.inflight), 8);
    do_reset();

    // Asynchronous reset at stage 3, pair 7, then a clean transform.
    auto_wb = 1'b1;
    begin_xfer();
    found = 1'b0;
    n = 0;
    while (!found && n < 500) begin
      cyc(1'b0, 1'b0);
      if (bus.stage == 3 && bus.pair_id == 7 && bus.busy) found = 1'b1;
      n++;
    end
    chk("rst_reach_s3p7", 32'(found), 1);
    #1;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.stall    = 1'b0;
    bus.wb_valid = 1'b0;
    #1;
    chk("rst_agu_valid", 32'(bus.agu_valid), 0);
    chk("rst_stage", 32'(bus.stage), 0);
    chk("rst_pair", 32'(bus.pair_id), 0);
    chk("rst_inflight", 32'(bus.inflight), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_model();
    repeat (3) cyc(1'b0, 1'b0);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_idle_busy", 32'(bus.busy), 0);
    begin_xfer();
    run_to_done("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
